// File: rtl/mem_bus_sequencer_pkg.sv
// mem_bus_sequencer_pkg
//   Shared definitions for the MEM-stage bus sequencer: the data-side memory map,
//   target codes produced by the address decoder, and the sequencer FSM states.
//   Reused by the store-byte logic, the exception checks and the bridge.
package mem_bus_sequencer_pkg;

    // Data-side memory map (inclusive byte address ranges)
    localparam logic [31:0] DM_START   = 32'h0000_0000;
    localparam logic [31:0] DM_END     = 32'h0000_2fff;
    localparam logic [31:0] TC0_START  = 32'h0000_7f00;
    localparam logic [31:0] TC0_END    = 32'h0000_7f0b;
    localparam logic [31:0] TC1_START  = 32'h0000_7f10;
    localparam logic [31:0] TC1_END    = 32'h0000_7f1b;
    localparam logic [31:0] WREG_START = 32'h0000_7f20;
    localparam logic [31:0] WREG_END   = 32'h0000_7f23;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_DM,
        TGT_TC0,
        TGT_TC1,
        TGT_WREG
    } target_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// mem_bus_sequencer_if
//   CPU-side request/response bus of the MEM-stage sequencer.
//   master : the CPU MEM stage (drives req_*, receives resp_*/stall)
//   slave  : the sequencer
//   req_valid/req_we/req_addr/req_byteen/req_wdata/req_flush : access request
//   resp_valid/resp_rdata : completion and load data
//   stall : pipeline freeze while DM wait states run
interface mem_bus_sequencer_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic        req_flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_byteen, req_wdata, req_flush,
        input  resp_valid, resp_rdata, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_byteen, req_wdata, req_flush,
        output resp_valid, resp_rdata, stall
    );

endinterface

// File: rtl/mem_bus_sequencer_decode.sv
// mem_addr_decode
//   Purely combinational byte address -> target code decoder.
//   addr   : 32-bit byte address
//   target : TGT_DM / TGT_TC0 / TGT_TC1 / TGT_WREG, or TGT_NONE when unmapped
module mem_addr_decode
    import mem_bus_sequencer_pkg::*;
(
    input  logic [31:0] addr,
    output target_t     target
);

    always_comb begin
        target = TGT_NONE;
        if (in_range(addr, DM_START, DM_END)) begin
            target = TGT_DM;
        end else if (in_range(addr, TC0_START, TC0_END)) begin
            target = TGT_TC0;
        end else if (in_range(addr, TC1_START, TC1_END)) begin
            target = TGT_TC1;
        end else if (in_range(addr, WREG_START, WREG_END)) begin
            target = TGT_WREG;
        end
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer
//   Routes the CPU MEM-stage data access to DM, TC0, TC1 or the wait-state
//   register (WAITREG). Non-DM targets, and DM with zero wait states, finish in
//   one cycle. DM with N>0 wait states stalls the pipeline for N cycles and
//   strobes DM once, in the completion cycle, with the latched request.
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   bus (slave)             : CPU request/response/stall
//   dm_en/addr/byteen/wdata : DM strobe and write data, dm_rdata async read data
//   tc0_we, tc1_we          : timer write strobes (word stores only)
//   tc0_addr, tc0_wdata     : shared timer word address and write data
//   tc0_rdata, tc1_rdata    : timer read data
//   wait_cfg                : current WAITREG value
module mem_bus_sequencer
    import mem_bus_sequencer_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int DEFAULT_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_sequencer_if.slave   bus,
    output logic                 dm_en,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_byteen,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    output logic                 tc0_we,
    output logic [29:0]          tc0_addr,
    output logic [31:0]          tc0_wdata,
    input  logic [31:0]          tc0_rdata,
    output logic                 tc1_we,
    input  logic [31:0]          tc1_rdata,
    output logic [CNT_W-1:0]     wait_cfg
);

    state_t            state;
    state_t            next_state;
    target_t           target;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       lat_addr;
    logic              lat_we;
    logic [3:0]        lat_byteen;
    logic [31:0]       lat_wdata;
    logic              issue_wait;
    logic              wreg_write;
    logic              req_live;
    logic              word_store;
    logic [31:0]       load_data;

    mem_addr_decode u_decode (
        .addr   (bus.req_addr),
        .target (target)
    );

    // Reset dominates flush; both kill a request in the cycle they appear,
    // so no strobe can escape while reset is asserted.
    assign req_live   = bus.req_valid && !bus.req_flush && !reset;
    assign word_store = bus.req_we && (bus.req_byteen == 4'b1111);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Wait-state counter, latched DM request and WAITREG.
    // The counter is cleared when WAIT exits (completion or flush).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_byteen <= '0;
            lat_wdata  <= '0;
            wait_cfg   <= CNT_W'(DEFAULT_WAIT);
        end else begin
            if (issue_wait) begin
                cnt        <= wait_cfg;
                lat_addr   <= bus.req_addr;
                lat_we     <= bus.req_we;
                lat_byteen <= bus.req_byteen;
                lat_wdata  <= bus.req_wdata;
            end else if (state == ST_WAIT) begin
                cnt <= (next_state == ST_IDLE) ? '0 : cnt - CNT_W'(1);
            end
            if (wreg_write) begin
                wait_cfg <= bus.req_wdata[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        next_state     = state;
        issue_wait     = 1'b0;
        wreg_write     = 1'b0;
        load_data      = '0;
        dm_en          = 1'b0;
        dm_addr        = '0;
        dm_byteen      = '0;
        dm_wdata       = '0;
        tc0_we         = 1'b0;
        tc1_we         = 1'b0;
        tc0_addr       = '0;
        tc0_wdata      = '0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.stall      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_live) begin
                    if ((target == TGT_DM) && (wait_cfg != '0)) begin
                        bus.stall  = 1'b1;
                        issue_wait = 1'b1;
                        next_state = ST_WAIT;
                    end else begin
                        bus.resp_valid = 1'b1;
                        case (target)
                            TGT_DM: begin
                                dm_en     = 1'b1;
                                dm_addr   = bus.req_addr;
                                dm_byteen = bus.req_we ? bus.req_byteen : 4'b0000;
                                dm_wdata  = bus.req_wdata;
                                load_data = dm_rdata;
                            end
                            TGT_TC0: begin
                                tc0_addr  = bus.req_addr[31:2];
                                tc0_wdata = bus.req_wdata;
                                tc0_we    = word_store;
                                load_data = tc0_rdata;
                            end
                            TGT_TC1: begin
                                tc0_addr  = bus.req_addr[31:2];
                                tc0_wdata = bus.req_wdata;
                                tc1_we    = word_store;
                                load_data = tc1_rdata;
                            end
                            TGT_WREG: begin
                                wreg_write = word_store;
                                load_data  = {{(32-CNT_W){1'b0}}, wait_cfg};
                            end
                            default: begin
                            end
                        endcase
                        if (!bus.req_we) begin
                            bus.resp_rdata = load_data;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!reset) begin
                    if (bus.req_flush) begin
                        next_state = ST_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        next_state     = ST_IDLE;
                        dm_en          = 1'b1;
                        dm_addr        = lat_addr;
                        dm_byteen      = lat_we ? lat_byteen : 4'b0000;
                        dm_wdata       = lat_wdata;
                        bus.resp_valid = 1'b1;
                        if (!lat_we) begin
                            bus.resp_rdata = dm_rdata;
                        end
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer
//   Self-checking bench for mem_bus_sequencer. A transaction-level model keeps
//   the WAITREG value and predicts, from the address map, the target, the
//   number of stall cycles, strobe counts and load data of every access.
module tb_mem_bus_sequencer;

    localparam int CNT_W    = 4;
    localparam int DEF_WAIT = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              dm_en;
    logic [31:0]       dm_addr;
    logic [3:0]        dm_byteen;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              tc0_we;
    logic [29:0]       tc0_addr;
    logic [31:0]       tc0_wdata;
    logic [31:0]       tc0_rdata;
    logic              tc1_we;
    logic [31:0]       tc1_rdata;
    logic [CNT_W-1:0]  wait_cfg;

    int n_tests = 0;
    int n_fail  = 0;
    int model_wait = DEF_WAIT;

    always #5 clk = ~clk;

    mem_bus_sequencer_if bus ();

    mem_bus_sequencer #(
        .CNT_W        (CNT_W),
        .DEFAULT_WAIT (DEF_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dm_en     (dm_en),
        .dm_addr   (dm_addr),
        .dm_byteen (dm_byteen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .tc0_we    (tc0_we),
        .tc0_addr  (tc0_addr),
        .tc0_wdata (tc0_wdata),
        .tc0_rdata (tc0_rdata),
        .tc1_we    (tc1_we),
        .tc1_rdata (tc1_rdata),
        .wait_cfg  (wait_cfg)
    );

    // 0 = unmapped, 1 = DM, 2 = TC0, 3 = TC1, 4 = WAITREG
    function automatic int classify(input logic [31:0] a);
        if (a <= 32'h2fff) return 1;
        if (a >= 32'h7f00 && a <= 32'h7f0b) return 2;
        if (a >= 32'h7f10 && a <= 32'h7f1b) return 3;
        if (a >= 32'h7f20 && a <= 32'h7f23) return 4;
        return 0;
    endfunction

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_byteen = '0;
        bus.req_wdata  = '0;
        bus.req_flush  = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_byteen = be;
        bus.req_wdata  = wd;
        bus.req_flush  = 1'b0;
    endtask

    // One complete access, entered and left at posedge+1.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             input string tag);
        int          tgt;
        int          exp_stall;
        int          stall_cnt;
        int          cycles;
        int          dm_cnt;
        int          tc0_cnt;
        int          tc1_cnt;
        int          exp_tc0;
        int          exp_tc1;
        bit          done;
        bit          word;
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        logic [31:0] got_dm_addr;
        logic [3:0]  got_dm_be;
        logic [31:0] got_dm_wdata;
        logic [29:0] got_tc_addr;
        logic [31:0] got_tc_wdata;

        dm_rdata  = $urandom;
        tc0_rdata = $urandom;
        tc1_rdata = $urandom;
        tgt       = classify(addr);
        word      = we && (be == 4'b1111);
        exp_stall = (tgt == 1) ? model_wait : 0;
        exp_tc0   = (tgt == 2 && word) ? 1 : 0;
        exp_tc1   = (tgt == 3 && word) ? 1 : 0;
        case (tgt)
            1:       exp_rdata = dm_rdata;
            2:       exp_rdata = tc0_rdata;
            3:       exp_rdata = tc1_rdata;
            4:       exp_rdata = 32'(model_wait);
            default: exp_rdata = 32'h0;
        endcase

        stall_cnt = 0; cycles = 0; dm_cnt = 0; tc0_cnt = 0; tc1_cnt = 0; done = 0;
        got_rdata = '0; got_dm_addr = '0; got_dm_be = '0; got_dm_wdata = '0;
        got_tc_addr = '0; got_tc_wdata = '0;

        drive_req(we, addr, be, wd);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.stall) stall_cnt++;
            if (dm_en) begin
                dm_cnt++;
                got_dm_addr  = dm_addr;
                got_dm_be    = dm_byteen;
                got_dm_wdata = dm_wdata;
            end
            if (tc0_we) tc0_cnt++;
            if (tc1_we) tc1_cnt++;
            if (bus.resp_valid) begin
                done         = 1;
                got_rdata    = bus.resp_rdata;
                got_tc_addr  = tc0_addr;
                got_tc_wdata = tc0_wdata;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();

        if (word && tgt == 4) model_wait = int'(wd[CNT_W-1:0]);

        n_tests++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL %s completion: no resp_valid within 40 cycles", tag);
        end
        n_tests++;
        if (cycles != exp_stall + 1 || stall_cnt != exp_stall) begin
            n_fail++;
            $display("[TB] FAIL %s latency: got %0d cycles / %0d stalls, expected %0d / %0d",
                     tag, cycles, stall_cnt, exp_stall + 1, exp_stall);
        end
        n_tests++;
        if (dm_cnt != ((tgt == 1) ? 1 : 0) || tc0_cnt != exp_tc0 || tc1_cnt != exp_tc1) begin
            n_fail++;
            $display("[TB] FAIL %s strobes: got dm=%0d tc0=%0d tc1=%0d, expected dm=%0d tc0=%0d tc1=%0d",
                     tag, dm_cnt, tc0_cnt, tc1_cnt, (tgt == 1) ? 1 : 0, exp_tc0, exp_tc1);
        end
        if (!we) begin
            n_tests++;
            if (got_rdata !== exp_rdata) begin
                n_fail++;
                $display("[TB] FAIL %s rdata: got %08h expected %08h", tag, got_rdata, exp_rdata);
            end
        end
        if (tgt == 1 && dm_cnt == 1) begin
            n_tests++;
            if (got_dm_addr !== addr || (we && (got_dm_be !== be || got_dm_wdata !== wd))) begin
                n_fail++;
                $display("[TB] FAIL %s dm_bus: got addr=%08h be=%h wd=%08h, expected addr=%08h be=%h wd=%08h",
                         tag, got_dm_addr, got_dm_be, got_dm_wdata, addr, be, wd);
            end
        end
        if (tgt == 2 || tgt == 3) begin
            n_tests++;
            if (got_tc_addr !== addr[31:2] || (word && got_tc_wdata !== wd)) begin
                n_fail++;
                $display("[TB] FAIL %s tc_bus: got addr=%h wd=%08h, expected addr=%h wd=%08h",
                         tag, got_tc_addr, got_tc_wdata, addr[31:2], wd);
            end
        end
        n_tests++;
        if (int'(wait_cfg) != model_wait) begin
            n_fail++;
            $display("[TB] FAIL %s wait_cfg: got %0d expected %0d", tag, wait_cfg, model_wait);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_req(1'b1, 32'h100, 4'b1111, 32'h1234_5678);
        dm_rdata = 32'h0; tc0_rdata = 32'h0; tc1_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (dm_en !== 1'b0 || bus.resp_valid !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_gating: got dm_en=%b resp_valid=%b stall=%b, expected 0 0 0",
                     dm_en, bus.resp_valid, bus.stall);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if (int'(wait_cfg) != DEF_WAIT || bus.stall !== 1'b0 || bus.resp_valid !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || dm_en !== 1'b0 || tc0_we !== 1'b0 || tc1_we !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got wait=%0d stall=%b rv=%b rd=%08h dm=%b t0=%b t1=%b, expected %0d and zeros",
                     wait_cfg, bus.stall, bus.resp_valid, bus.resp_rdata, dm_en, tc0_we, tc1_we, DEF_WAIT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dm_no_wait();
        do_access(1'b1, 32'h100, 4'b1111, 32'hdead_beef, "dm_store_w0");
        do_access(1'b0, 32'h100, 4'b0000, 32'h0, "dm_load_w0");
    endtask

    task automatic test_wait_load();
        do_access(1'b1, 32'h7f20, 4'b1111, 32'h3, "wreg_store3");
        do_access(1'b0, 32'h7f20, 4'b0000, 32'h0, "wreg_load");
        do_access(1'b0, 32'h200, 4'b0000, 32'h0, "dm_load_w3");
    endtask

    task automatic test_flush();
        int dm_seen;
        int stall_seen;
        drive_req(1'b1, 32'h300, 4'b1111, $urandom);
        @(negedge clk);
        n_tests++;
        if (bus.stall !== 1'b1 || dm_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_issue: got stall=%b dm_en=%b, expected 1 0", bus.stall, dm_en);
        end
        @(posedge clk);
        #1;
        bus.req_flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.stall !== 1'b0 || dm_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_cycle: got stall=%b dm_en=%b rv=%b, expected 0 0 0",
                     bus.stall, dm_en, bus.resp_valid);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        dm_seen = 0; stall_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dm_en) dm_seen++;
            if (bus.stall) stall_seen++;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (dm_seen != 0 || stall_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_after: got dm_en=%0d stall=%0d cycles, expected 0 0", dm_seen, stall_seen);
        end
        do_access(1'b0, 32'h4000, 4'b0000, 32'h0, "post_flush_unmapped");
        do_access(1'b0, 32'h200, 4'b0000, 32'h0, "post_flush_dm");
    endtask

    task automatic test_timers();
        do_access(1'b1, 32'h7f04, 4'b0011, 32'hffff_0001, "tc0_partial");
        do_access(1'b1, 32'h7f14, 4'b1111, 32'h0bad_cafe, "tc1_word");
        do_access(1'b1, 32'h7f08, 4'b1111, 32'h1111_2222, "tc0_word");
        do_access(1'b0, 32'h7f00, 4'b0000, 32'h0, "tc0_load");
        do_access(1'b0, 32'h7f18, 4'b0000, 32'h0, "tc1_load");
    endtask

    task automatic test_unmapped();
        do_access(1'b0, 32'h4000, 4'b0000, 32'h0, "unmapped_load");
        do_access(1'b0, 32'h3000, 4'b0000, 32'h0, "dm_end_plus1");
        do_access(1'b1, 32'h7f0c, 4'b1111, 32'h5, "tc0_end_plus1");
        do_access(1'b0, 32'h2ffc, 4'b0000, 32'h0, "dm_last_word");
    endtask

    task automatic test_max_wait();
        do_access(1'b1, 32'h7f20, 4'b1111, 32'hffff_fff0 | 32'hf, "wreg_store15");
        do_access(1'b0, 32'h1000, 4'b0000, 32'h0, "dm_load_w15");
        do_access(1'b1, 32'h1004, 4'b0000, 32'h0, "dm_fault_store_w15");
    endtask

    task automatic test_reset_in_wait();
        int dm_seen;
        do_access(1'b1, 32'h7f20, 4'b1111, 32'h5, "wreg_store5");
        drive_req(1'b1, 32'h40, 4'b1111, 32'hcafe_f00d);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dm_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_wait_strobe: got dm_en=%b rv=%b, expected 0 0", dm_en, bus.resp_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        model_wait = DEF_WAIT;
        @(negedge clk);
        n_tests++;
        if (int'(wait_cfg) != DEF_WAIT || bus.stall !== 1'b0 || dm_en !== 1'b0 ||
            bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_wait_after: got wait=%0d stall=%b dm=%b rv=%b rd=%08h, expected %0d and zeros",
                     wait_cfg, bus.stall, dm_en, bus.resp_valid, bus.resp_rdata, DEF_WAIT);
        end
        dm_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dm_en) dm_seen++;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (dm_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_wait_late: got %0d dm_en cycles, expected 0", dm_seen);
        end
        do_access(1'b0, 32'h40, 4'b0000, 32'h0, "post_reset_dm");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 5))
                0, 1: addr = {18'h0, 12'($urandom_range(0, 12'hbff)), 2'b00};
                2:    addr = 32'h7f00 + 32'(4 * $urandom_range(0, 2));
                3:    addr = 32'h7f10 + 32'(4 * $urandom_range(0, 2));
                4: begin
                    addr = 32'h7f20;
                    wd   = {wd[31:4], 4'($urandom_range(0, 4))};
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0:       addr = 32'h3000;
                        1:       addr = 32'h7f1c;
                        2:       addr = 32'h7f24;
                        default: addr = 32'h8000 + $urandom_range(0, 32'hffff);
                    endcase
                end
            endcase
            case ($urandom_range(0, 3))
                0:       be = 4'b0011;
                1:       be = 4'b0000;
                default: be = 4'b1111;
            endcase
            if (!we) be = 4'b0000;
            do_access(we, addr, be, wd, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        idle_inputs();
        reset     = 1'b1;
        dm_rdata  = '0;
        tc0_rdata = '0;
        tc1_rdata = '0;
        test_reset();
        test_dm_no_wait();
        test_wait_load();
        test_flush();
        test_timers();
        test_unmapped();
        test_max_wait();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
